// File: rtl/fft_butterfly_stage.sv
// ---------------------------------------------------------------------------
// fft_butterfly_stage
//   One radix-2 decimation-in-time stage of a 1024-point FFT. The stage walks
//   512 butterflies. Each butterfly reads x0 = X[i0], x1 = X[i1] and the
//   twiddle W[tw], then writes OUT[i0] = x0 + x1*W and OUT[i1] = x0 - x1*W.
//   Sample data is 32-bit signed. Twiddles are Q1.15. The product is scaled
//   back by an arithmetic shift of 15, which rounds toward minus infinity.
//   All sums wrap at 32 bits.
//
// Ports
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   ap_start, ap_continue     block-level control inputs
//   ap_done, ap_idle,         block-level status outputs
//   ap_ready
//   X_{R,I}_address0/ce0/q0   input array read port (1-cycle latency)
//   W_{R,I}_address0/ce0/q0   twiddle ROM read port (1-cycle latency)
//   OUT_{R,I}_address0/ce0/   output array write port
//   we0/d0
//   o_dbg_state               one-hot FSM state, for observation only
//
// Handshake
//   A run starts on a cycle in IDLE where ap_start=1 and no done is pending.
//   ap_start is ignored in every other state. ap_done and ap_ready pulse in
//   the final CHK cycle. If ap_continue is low in that cycle, ap_done stays
//   high until ap_continue is seen high. While done is held, no new start is
//   taken.
// ---------------------------------------------------------------------------
module fft_butterfly_stage #(
  parameter int STAGE = 0
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  input  logic        ap_continue,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [9:0]  X_R_address0,
  output logic        X_R_ce0,
  input  logic [31:0] X_R_q0,
  output logic [9:0]  X_I_address0,
  output logic        X_I_ce0,
  input  logic [31:0] X_I_q0,
  output logic [8:0]  W_R_address0,
  output logic        W_R_ce0,
  input  logic [15:0] W_R_q0,
  output logic [8:0]  W_I_address0,
  output logic        W_I_ce0,
  input  logic [15:0] W_I_q0,
  output logic [9:0]  OUT_R_address0,
  output logic        OUT_R_ce0,
  output logic        OUT_R_we0,
  output logic [31:0] OUT_R_d0,
  output logic [9:0]  OUT_I_address0,
  output logic        OUT_I_ce0,
  output logic        OUT_I_we0,
  output logic [31:0] OUT_I_d0,
  output logic [5:0]  o_dbg_state
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_CHK  = 6'b000010,
    S_RD1  = 6'b000100,
    S_CALC = 6'b001000,
    S_WR0  = 6'b010000,
    S_WR1  = 6'b100000
  } state_t;

  localparam int SPAN = 1 << STAGE;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_done_reg;
  logic [9:0]  r_b;
  logic [31:0] r_x0_r, r_x0_i, r_x1_r, r_x1_i, r_t_r, r_t_i;
  logic [15:0] r_w_r, r_w_i;

  logic        w_start_ok;
  logic        w_done_pulse;
  logic        w_x_ce, w_w_ce, w_out_we;
  logic [9:0]  w_x_addr, w_out_addr;
  logic [31:0] w_out_d_r, w_out_d_i;

  // Butterfly addressing.
  logic [31:0] w_b32, w_j32;
  logic [9:0]  w_i0, w_i1;
  logic [8:0]  w_tw;

  assign w_b32 = {22'd0, r_b};
  assign w_j32 = w_b32 & 32'(SPAN - 1);
  assign w_i0  = 10'(((w_b32 >> STAGE) << (STAGE + 1)) | w_j32);
  assign w_i1  = w_i0 + 10'(SPAN);
  assign w_tw  = 9'(w_j32 << (9 - STAGE));

  // Complex multiply t = x1 * w.
  // x1 is registered at the end of CALC, so t is formed combinationally
  // during WR0 from registered operands. It is registered at the end of WR0
  // so that WR1 reuses it without holding the multiplier path.
  // The products need 48 bits. Their sum is carried in 49 bits so that it
  // cannot overflow.
  logic signed [48:0] w_x1r_e, w_x1i_e, w_wr_e, w_wi_e;
  logic signed [48:0] w_sum_r, w_sum_i, w_shr_r, w_shr_i;
  logic        [31:0] w_t_r, w_t_i;
  logic               w_unused_hi;

  assign w_x1r_e = {{17{r_x1_r[31]}}, r_x1_r};
  assign w_x1i_e = {{17{r_x1_i[31]}}, r_x1_i};
  assign w_wr_e  = {{33{r_w_r[15]}}, r_w_r};
  assign w_wi_e  = {{33{r_w_i[15]}}, r_w_i};
  assign w_sum_r = (w_x1r_e * w_wr_e) - (w_x1i_e * w_wi_e);
  assign w_sum_i = (w_x1r_e * w_wi_e) + (w_x1i_e * w_wr_e);
  assign w_shr_r = w_sum_r >>> 15;
  assign w_shr_i = w_sum_i >>> 15;
  assign w_t_r   = w_shr_r[31:0];
  assign w_t_i   = w_shr_i[31:0];
  // The bits above 32 are dropped. Results wrap rather than saturate.
  assign w_unused_hi = ^{w_shr_r[48:32], w_shr_i[48:32]};

  assign w_start_ok = ap_start && !r_done_reg;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_done_reg <= 1'b0;
      r_b        <= 10'd0;
      r_x0_r     <= 32'd0;
      r_x0_i     <= 32'd0;
      r_x1_r     <= 32'd0;
      r_x1_i     <= 32'd0;
      r_t_r      <= 32'd0;
      r_t_i      <= 32'd0;
      r_w_r      <= 16'd0;
      r_w_i      <= 16'd0;
    end else begin
      r_state <= w_state_next;
      // ap_continue wins over a simultaneous done pulse.
      if (ap_continue) begin
        r_done_reg <= 1'b0;
      end else if (w_done_pulse) begin
        r_done_reg <= 1'b1;
      end
      if (r_state == S_IDLE && w_start_ok) begin
        r_b <= 10'd0;
      end else if (r_state == S_WR1) begin
        r_b <= r_b + 10'd1;
      end
      if (r_state == S_RD1) begin
        r_x0_r <= X_R_q0;
        r_x0_i <= X_I_q0;
        r_w_r  <= W_R_q0;
        r_w_i  <= W_I_q0;
      end
      if (r_state == S_CALC) begin
        r_x1_r <= X_R_q0;
        r_x1_i <= X_I_q0;
      end
      if (r_state == S_WR0) begin
        r_t_r <= w_t_r;
        r_t_i <= w_t_i;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_pulse = 1'b0;
    w_x_ce       = 1'b0;
    w_w_ce       = 1'b0;
    w_out_we     = 1'b0;
    w_x_addr     = w_i0;
    w_out_addr   = w_i0;
    w_out_d_r    = r_x0_r + w_t_r;
    w_out_d_i    = r_x0_i + w_t_i;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_CHK;
      end
      S_CHK: begin
        if (r_b == 10'd512) begin
          w_done_pulse = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_x_ce       = 1'b1;
          w_w_ce       = 1'b1;
          w_state_next = S_RD1;
        end
      end
      S_RD1: begin
        w_x_addr     = w_i1;
        w_x_ce       = 1'b1;
        w_state_next = S_CALC;
      end
      S_CALC: begin
        w_state_next = S_WR0;
      end
      S_WR0: begin
        w_out_we     = 1'b1;
        w_state_next = S_WR1;
      end
      S_WR1: begin
        w_out_we     = 1'b1;
        w_out_addr   = w_i1;
        w_out_d_r    = r_x0_r - r_t_r;
        w_out_d_i    = r_x0_i - r_t_i;
        w_state_next = S_CHK;
      end
      default: w_state_next = S_IDLE;
    endcase
    // While reset is asserted, memory strobes and done/ready stay low,
    // whatever state the register still holds.
    if (!ap_rst_n) begin
      w_done_pulse = 1'b0;
      w_x_ce       = 1'b0;
      w_w_ce       = 1'b0;
      w_out_we     = 1'b0;
    end
  end

  assign ap_done  = w_done_pulse || (r_done_reg && ap_rst_n);
  assign ap_ready = w_done_pulse;
  assign ap_idle  = (r_state == S_IDLE) && !ap_start;

  assign X_R_address0   = w_x_addr;
  assign X_I_address0   = w_x_addr;
  assign X_R_ce0        = w_x_ce;
  assign X_I_ce0        = w_x_ce;
  assign W_R_address0   = w_tw;
  assign W_I_address0   = w_tw;
  assign W_R_ce0        = w_w_ce;
  assign W_I_ce0        = w_w_ce;
  assign OUT_R_address0 = w_out_addr;
  assign OUT_I_address0 = w_out_addr;
  assign OUT_R_ce0      = w_out_we;
  assign OUT_I_ce0      = w_out_we;
  assign OUT_R_we0      = w_out_we;
  assign OUT_I_we0      = w_out_we;
  assign OUT_R_d0       = w_out_d_r;
  assign OUT_I_d0       = w_out_d_i;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// ---------------------------------------------------------------------------
// tb_fft_butterfly_stage
//   Bench for fft_butterfly_stage. It builds one instance with STAGE=0
//   (index 0) and one with STAGE=9 (index 1). Each instance has its own
//   behavioural X, W and OUT memories, and each memory read has one cycle of
//   latency. Hand-computed butterfly vectors are loaded into the memories of
//   the STAGE=9 instance. The remaining sequences cover cycle count,
//   done/continue holding, and reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_fft_butterfly_stage;

  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_CHK  = 6'b000010;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start[2], cont[2], done[2], idle[2], ready[2];
  logic [9:0]  xr_a[2], xi_a[2];
  logic        xr_ce[2], xi_ce[2];
  logic [31:0] xr_q[2], xi_q[2];
  logic [8:0]  wr_a[2], wi_a[2];
  logic        wr_ce[2], wi_ce[2];
  logic [15:0] wr_q[2], wi_q[2];
  logic [9:0]  or_a[2], oi_a[2];
  logic        or_ce[2], oi_ce[2], or_we[2], oi_we[2];
  logic [31:0] or_d[2], oi_d[2];
  logic [5:0]  dbg[2];

  logic [31:0] x_r[2][1024], x_i[2][1024], out_r[2][1024], out_i[2][1024];
  logic [15:0] w_r[2][512], w_i[2][512];
  int          wr_total[2];
  int          cnt9[1024];
  logic [9:0]  wlog9[$], rlog9[$];
  logic [8:0]  twlog9[$];

  fft_butterfly_stage #(.STAGE(0)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start[0]), .ap_continue(cont[0]),
    .ap_done(done[0]), .ap_idle(idle[0]), .ap_ready(ready[0]),
    .X_R_address0(xr_a[0]), .X_R_ce0(xr_ce[0]), .X_R_q0(xr_q[0]),
    .X_I_address0(xi_a[0]), .X_I_ce0(xi_ce[0]), .X_I_q0(xi_q[0]),
    .W_R_address0(wr_a[0]), .W_R_ce0(wr_ce[0]), .W_R_q0(wr_q[0]),
    .W_I_address0(wi_a[0]), .W_I_ce0(wi_ce[0]), .W_I_q0(wi_q[0]),
    .OUT_R_address0(or_a[0]), .OUT_R_ce0(or_ce[0]), .OUT_R_we0(or_we[0]), .OUT_R_d0(or_d[0]),
    .OUT_I_address0(oi_a[0]), .OUT_I_ce0(oi_ce[0]), .OUT_I_we0(oi_we[0]), .OUT_I_d0(oi_d[0]),
    .o_dbg_state(dbg[0])
  );

  fft_butterfly_stage #(.STAGE(9)) u_dut9 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start[1]), .ap_continue(cont[1]),
    .ap_done(done[1]), .ap_idle(idle[1]), .ap_ready(ready[1]),
    .X_R_address0(xr_a[1]), .X_R_ce0(xr_ce[1]), .X_R_q0(xr_q[1]),
    .X_I_address0(xi_a[1]), .X_I_ce0(xi_ce[1]), .X_I_q0(xi_q[1]),
    .W_R_address0(wr_a[1]), .W_R_ce0(wr_ce[1]), .W_R_q0(wr_q[1]),
    .W_I_address0(wi_a[1]), .W_I_ce0(wi_ce[1]), .W_I_q0(wi_q[1]),
    .OUT_R_address0(or_a[1]), .OUT_R_ce0(or_ce[1]), .OUT_R_we0(or_we[1]), .OUT_R_d0(or_d[1]),
    .OUT_I_address0(oi_a[1]), .OUT_I_ce0(oi_ce[1]), .OUT_I_we0(oi_we[1]), .OUT_I_d0(oi_d[1]),
    .o_dbg_state(dbg[1])
  );

  // Memory models, write counting and access logs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (xr_ce[k]) xr_q[k] <= x_r[k][xr_a[k]];
      if (xi_ce[k]) xi_q[k] <= x_i[k][xi_a[k]];
      if (wr_ce[k]) wr_q[k] <= w_r[k][wr_a[k]];
      if (wi_ce[k]) wi_q[k] <= w_i[k][wi_a[k]];
      if (or_ce[k] && or_we[k]) begin
        out_r[k][or_a[k]] <= or_d[k];
        wr_total[k] <= wr_total[k] + 1;
      end
      if (oi_ce[k] && oi_we[k]) out_i[k][oi_a[k]] <= oi_d[k];
    end
    if (or_ce[1] && or_we[1]) begin
      wlog9.push_back(or_a[1]);
      cnt9[or_a[1]] <= cnt9[or_a[1]] + 1;
    end
    if (xr_ce[1]) rlog9.push_back(xr_a[1]);
    if (wr_ce[1]) twlog9.push_back(wr_a[1]);
  end

  // Scoreboard.
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] x0r, x0i, x1r, x1i;
    logic [15:0] wr, wi;
    logic [31:0] e0r, e0i, e1r, e1i;
  } vec_t;

  function automatic vec_t mk(input int x0r, input int x0i, input int x1r, input int x1i,
                              input int wr, input int wi,
                              input int e0r, input int e0i, input int e1r, input int e1i);
    vec_t v;
    v.x0r = x0r; v.x0i = x0i; v.x1r = x1r; v.x1i = x1i;
    v.wr = 16'(wr); v.wi = 16'(wi);
    v.e0r = e0r; v.e0i = e0i; v.e1r = e1r; v.e1i = e1i;
    return v;
  endfunction

  vec_t vecs[8];

  // Driver: start a run and count cycles from the accept cycle to the first
  // cycle in which done is seen. The wait is capped at 4000 cycles.
  task automatic run_to_done(input int k, output int cyc, output logic rdy);
    cyc = 0;
    rdy = 1'b0;
    @(negedge clk);
    start[k] = 1'b1;
    while (cyc < 4000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start[k] = 1'b0;
      if (done[k]) begin
        rdy = ready[k];
        break;
      end
    end
  endtask

  initial begin
    int   cyc;
    logic rdy;
    int   bad;
    int   n_before;
    logic found;

    rst_n = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    cont[0] = 1'b1;  cont[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 1024; a++) begin
        x_r[k][a] = 32'd0;
        x_i[k][a] = 32'd0;
      end
      for (int a = 0; a < 512; a++) begin
        w_r[k][a] = 16'd0;
        w_i[k][a] = 16'd0;
      end
    end

    //           x0r           x0i           x1r           x1i           wr     wi      e0r           e0i           e1r           e1i
    vecs[0] = mk(1000,         0,            200,          0,            16384, 0,      1100,         0,            900,          0);
    vecs[1] = mk(0,            0,            -3,           0,            16384, 0,      -2,           0,            2,            0);
    vecs[2] = mk(10,           20,           32768,        -32768,       0,     -32768, -32758,       -32748,       32778,        32788);
    vecs[3] = mk(5,            -7,           100,          50,           16384, 16384,  30,           68,           -20,          -82);
    vecs[4] = mk(0,            0,            1,            1,            -1,    -1,     0,            -1,           0,            1);
    vecs[5] = mk(32'h7FFFFFFF, 32'h80000000, 2,            2,            16384, 0,      32'h80000000, 32'h80000001, 32'h7FFFFFFE, 32'h7FFFFFFF);
    vecs[6] = mk(0,            0,            32'h7FFFFFFF, 32'h7FFFFFFF, 32767, -32768, 32'hFFFEFFFE, 32'hFFFF0000, 32'h00010002, 32'h00010000);
    vecs[7] = mk(-100,         300,          -98304,       65536,        -32768, 16384, 65436,        -114388,      -65636,       114988);

    // With STAGE=9, butterfly b reads X[b] and X[b+512] and uses twiddle W[b].
    for (int e = 0; e < 8; e++) begin
      x_r[1][e] = vecs[e].x0r;       x_i[1][e] = vecs[e].x0i;
      x_r[1][e + 512] = vecs[e].x1r; x_i[1][e + 512] = vecs[e].x1i;
      w_r[1][e] = vecs[e].wr;        w_i[1][e] = vecs[e].wi;
    end
    // With STAGE=0, butterfly b reads X[2b] and X[2b+1], and W[0] is always used.
    x_r[0][0] = 32'd1000;      x_r[0][1] = 32'd200;
    x_r[0][2] = 32'd0;         x_r[0][3] = -32'sd3;
    x_r[0][4] = 32'h7FFFFFFF;  x_r[0][5] = 32'd2;
    w_r[0][0] = 16'd16384;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_done%0d", k),  64'(done[k]),  64'd0);
      check($sformatf("rst_ready%0d", k), 64'(ready[k]), 64'd0);
      check($sformatf("rst_xce%0d", k),   64'(xr_ce[k]), 64'd0);
      check($sformatf("rst_wce%0d", k),   64'(wr_ce[k]), 64'd0);
      check($sformatf("rst_we%0d", k),    64'(or_we[k] | oi_we[k]), 64'd0);
      check($sformatf("rst_idle%0d", k),  64'(idle[k]),  64'd1);
      check($sformatf("rst_state%0d", k), 64'(dbg[k]),   64'(ST_IDLE));
    end
    rst_n = 1'b1;
    @(negedge clk);

    // STAGE=9 full run, checked against the vector table.
    run_to_done(1, cyc, rdy);
    check("s9_cycles", 64'(cyc), 64'd2561);
    check("s9_ready", 64'(rdy), 64'd1);
    @(negedge clk);
    check("s9_done_pulse", 64'(done[1]), 64'd0);
    check("s9_idle_after", 64'(idle[1]), 64'd1);
    for (int e = 0; e < 8; e++) begin
      check($sformatf("s9_v%0d_o0r", e), 64'(out_r[1][e]),       64'(vecs[e].e0r));
      check($sformatf("s9_v%0d_o0i", e), 64'(out_i[1][e]),       64'(vecs[e].e0i));
      check($sformatf("s9_v%0d_o1r", e), 64'(out_r[1][e + 512]), 64'(vecs[e].e1r));
      check($sformatf("s9_v%0d_o1i", e), 64'(out_i[1][e + 512]), 64'(vecs[e].e1i));
    end
    check("s9_zero_r300", 64'(out_r[1][300]), 64'd0);
    check("s9_zero_i900", 64'(out_i[1][900]), 64'd0);
    bad = 0;
    for (int a = 0; a < 1024; a++) if (cnt9[a] != 1) bad++;
    check("s9_write_once", 64'(bad), 64'd0);
    check("s9_write_total", 64'(wr_total[1]), 64'd1024);
    check("s9_read_total", 64'(rlog9.size()), 64'd1024);
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(10'(b));
      exp_q.push_back(10'(b + 512));
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("s9_wr_order%0d", i), 64'(wlog9[i]), 64'(exp_q.pop_front()));
    end
    check("s9_b5_rd_i0", 64'(rlog9[10]), 64'd5);
    check("s9_b5_rd_i1", 64'(rlog9[11]), 64'd517);
    check("s9_b5_tw",    64'(twlog9[5]), 64'd5);

    // STAGE=0 run with ap_continue low, so done must be held.
    cont[0] = 1'b0;
    run_to_done(0, cyc, rdy);
    check("s0_cycles", 64'(cyc), 64'd2561);
    check("s0_ready", 64'(rdy), 64'd1);
    check("s0_out_r0", 64'(out_r[0][0]), 64'd1100);
    check("s0_out_r1", 64'(out_r[0][1]), 64'd900);
    check("s0_floor_r2", 64'(out_r[0][2]), 64'hFFFFFFFE);
    check("s0_floor_r3", 64'(out_r[0][3]), 64'd2);
    check("s0_wrap_r4", 64'(out_r[0][4]), 64'h80000000);
    check("s0_wrap_r5", 64'(out_r[0][5]), 64'h7FFFFFFE);
    for (int a = 0; a < 6; a++) check($sformatf("s0_out_i%0d", a), 64'(out_i[0][a]), 64'd0);
    check("s0_out_r1023", 64'(out_r[0][1023]), 64'd0);

    // While done is held, a new start must be ignored.
    start[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hold_done%0d", i),  64'(done[0]),  64'd1);
      check($sformatf("hold_ready%0d", i), 64'(ready[0]), 64'd0);
      check($sformatf("hold_xce%0d", i),   64'(xr_ce[0]), 64'd0);
      check($sformatf("hold_state%0d", i), 64'(dbg[0]),   64'(ST_IDLE));
    end
    cont[0] = 1'b1;
    @(negedge clk);
    check("cont_done_low", 64'(done[0]), 64'd0);
    check("cont_still_idle", 64'(dbg[0]), 64'(ST_IDLE));
    @(negedge clk);
    check("cont_accept_state", 64'(dbg[0]), 64'(ST_CHK));
    check("cont_accept_xce", 64'(xr_ce[0]), 64'd1);
    start[0] = 1'b0;

    // Reset during WR0 of butterfly 100. With STAGE=0 that write goes to i0=200.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (or_we[0] && or_a[0] == 10'd200) found = 1'b1;
    end
    check("wr0_b100_found", 64'(found), 64'd1);
    rst_n = 1'b0;
    n_before = wr_total[0];
    #1;
    check("rst_gates_we", 64'(or_we[0]), 64'd0);
    @(negedge clk);
    check("abort_state", 64'(dbg[0]), 64'(ST_IDLE));
    check("abort_we", 64'(or_we[0] | oi_we[0]), 64'd0);
    check("abort_idle", 64'(idle[0]), 64'd1);
    check("abort_done", 64'(done[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_writes", 64'(wr_total[0]), 64'(n_before));
    check("abort_stay_idle", 64'(dbg[0]), 64'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_stage.md
FFT_BUTTERFLY_STAGE -- requirements
Module: fft_butterfly_stage

Interface
REQ-001 SHALL have parameter: STAGE, default 0, radix-2 stage index 0..9 for a 1024-point FFT; span = 2^STAGE.
REQ-002 SHALL have ports, clock and reset first:
- ap_clk  in  1  sole clock; all state updates on its rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- ap_start  in  1  start request.
- ap_continue  in  1  downstream acknowledges done.
- ap_done / ap_idle / ap_ready  out  1 each  block-level handshake.
- X_R_address0, X_I_address0  out  10  input (bit-reversed) array read address.
- X_R_ce0, X_I_ce0  out  1  read enables; 1-cycle read latency.
- X_R_q0, X_I_q0  in  32  signed real/imag input data.
- W_R_address0, W_I_address0  out  9  twiddle ROM address.
- W_R_ce0, W_I_ce0  out  1  twiddle read enables; 1-cycle latency.
- W_R_q0, W_I_q0  in  16  signed Q1.15 twiddle real/imag.
- OUT_R_address0, OUT_I_address0  out  10  output array address.
- OUT_R_ce0, OUT_I_ce0, OUT_R_we0, OUT_I_we0  out  1  output enables.
- OUT_R_d0, OUT_I_d0  out  32  output data.

Function
REQ-003 SHALL implement one-hot FSM: IDLE, CHK, RD1, CALC, WR0, WR1.
REQ-004 SHALL hold 10-bit butterfly counter b; cleared to 0 when start accepted in IDLE; incremented in WR1.
REQ-005 SHALL, for each b, compute j = b mod span, i0 = (b >> STAGE)*2*span + j, i1 = i0 + span, twiddle index tw = j << (9-STAGE).
REQ-006 SHALL accept start in IDLE only when ap_start=1 and ap_done_reg=0; next state CHK.
REQ-007 SHALL in CHK with b=512: assert ap_done and ap_ready for that cycle, issue no reads, return to IDLE.
REQ-008 SHALL in CHK with b<512: drive X_*_address0=i0 and W_*_address0=tw with ce=1; next RD1.
REQ-009 SHALL in RD1: capture X_R_q0/X_I_q0 as x0 and W_*_q0 as w; drive X_*_address0=i1 with ce=1; next CALC.
REQ-010 SHALL in CALC: capture x1; compute t_r = (x1r*wr - x1i*wi) >>> 15 and t_i = (x1r*wi + x1i*wr) >>> 15, using 49-bit signed sums, arithmetic shift (floor), low 32 bits kept; next WR0.
REQ-011 SHALL in WR0 write OUT_*[i0] = x0 + t (32-bit wrap), and in WR1 write OUT_*[i1] = x0 - t (32-bit wrap), ce=we=1 both cycles; WR1 next CHK.
REQ-012 SHALL deassert all ce/we outside states named above; addresses don't-care then.
REQ-013 SHALL take exactly 5 cycles per butterfly; ap_done 2561 cycles after start-accept cycle.
REQ-014 SHALL set ap_done_reg when done fires and ap_continue=0; clear on ap_continue=1 (ap_continue has priority); ap_done = done pulse OR ap_done_reg.
REQ-015 SHALL drive ap_idle=1 only in IDLE with ap_start=0.
REQ-016 SHALL ignore ap_start outside IDLE; no mid-run restart.

Reset
REQ-017 SHALL, on ap_rst_n=0 at a clock edge, enter IDLE, clear ap_done_reg, b and x0/x1/w/t registers to 0, regardless of state.
REQ-018 SHALL during and after reset hold all ce/we, ap_done and ap_ready at 0; ap_idle follows REQ-015.
REQ-019 SHALL abort a run when reset occurs mid-operation; no further writes until a new start.

Verification
REQ-020 STAGE=0, X_R[0]=1000, X_R[1]=200, X_I=0, W_R[0]=16384, W_I[0]=0 -> OUT_R[0]=1100, OUT_R[1]=900, OUT_I[0..1]=0.
REQ-021 STAGE=0, X_R[1]=-3, X_R[0]=0, W_R[0]=16384 -> t_r=-2 (floor); OUT_R[0]=-2, OUT_R[1]=2.
REQ-022 STAGE=9, b=5 -> reads addresses 5 and 517, twiddle address 5; writes 5 then 517; full run 2561 cycles start-to-done, 1024 writes per array, each address once.
REQ-023 X_R[0]=0x7FFFFFFF, t_r=1 -> OUT_R[i0]=0x80000000 (wrap, no saturation).
REQ-024 ap_continue=0 at done -> ap_done held high, new ap_start ignored; ap_continue=1 -> ap_done low next cycle, start accepted.
REQ-025 ap_rst_n=0 during WR0 of butterfly 100 -> next cycle IDLE, all we=0, ap_idle=1 if ap_start=0.
